mdu_hilo: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the execute stage directly downstream of the main instruction decoder. Consumes the decoder's `md_op`, `start` and `mdm_sel` outputs plus the forwarded rs/rt operands. Runs MULT/MULTU/DIV/DIVU with a fixed-latency busy window, services MTHI/MTLO writes, and returns HI or LO for MFHI/MFLO. Exports `busy` to the hazard unit for stalling.

---
 rtl/mdu_hilo_pkg.sv | 25 ++
 rtl/mdu_hilo_if.sv | 27 ++
 rtl/mdu_hilo_arith.sv | 50 +++++
 rtl/mdu_hilo.sv | 92 +++++++++
 tb/tb_mdu_hilo.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the multiply/divide unit and its HI/LO registers.
// Operation encodings, default latencies and the FSM state type.
package mdu_hilo_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide unit.
// The pipeline side is the master; the unit itself is the slave.
interface mdu_hilo_if;

    logic [2:0]  md_op;
    logic        start;
    logic        md_we;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        mdm_sel;
    logic [31:0] hilo_rdata;
    logic        busy;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    modport master (
        output md_op, start, md_we, src_a, src_b, cancel, mdm_sel,
        input  hilo_rdata, busy, hi_q, lo_q
    );

    modport slave (
        input  md_op, start, md_we, src_a, src_b, cancel, mdm_sel,
        output hilo_rdata, busy, hi_q, lo_q
    );

endinterface

// File: rtl/mdu_hilo_arith.sv
// Combinational multiply/divide datapath producing {HI, LO}.
// Signed ops work on magnitudes and fix the sign afterwards.
module mdu_arith
    import mdu_hilo_pkg::*;
(
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_res
);

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_div;
    logic [63:0] w_prod_mag;
    logic [63:0] w_prod;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_signed = ~i_op[0];
    assign w_a_neg  = w_signed & i_a[31];
    assign w_b_neg  = w_signed & i_b[31];

    always_comb begin
        w_a_mag = w_a_neg ? (~i_a + 32'd1) : i_a;
        w_b_mag = w_b_neg ? (~i_b + 32'd1) : i_b;
        w_prod_mag = {32'd0, w_a_mag} * {32'd0, w_b_mag};
        w_prod = (w_a_neg ^ w_b_neg) ? (~w_prod_mag + 64'd1) : w_prod_mag;
        // Zero divisor is special-cased below; keep the divider well defined.
        w_b_div = (i_b == 32'd0) ? 32'd1 : w_b_mag;
        w_q_mag = w_a_mag / w_b_div;
        w_r_mag = w_a_mag % w_b_div;
        w_q = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
        w_r = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
        o_res = w_prod;
        if (i_op[1]) begin
            if (i_b == 32'd0) begin
                o_res = {i_a, 32'hFFFF_FFFF};
            end else begin
                o_res = {w_r, w_q};
            end
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Result is computed at launch and committed after a fixed busy window.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    mdu_hilo_if.slave  bus
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [63:0]      r_pend;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic [63:0]      w_res;
    logic             w_launch;
    logic             w_mt_wr;

    mdu_arith u_arith (
        .i_op  (bus.md_op[1:0]),
        .i_a   (bus.src_a),
        .i_b   (bus.src_b),
        .o_res (w_res)
    );

    assign w_launch = bus.start & ~bus.md_op[2] & ~bus.cancel;
    // 110/111 are reserved and must not touch HI/LO.
    assign w_mt_wr  = bus.md_we & bus.md_op[2] & ~bus.md_op[1]
                    & ~bus.cancel;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_pend  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_pend  <= w_res;
                        r_cnt   <= is_div(bus.md_op) ? DIV_LOAD : MULT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else if (w_mt_wr) begin
                        if (bus.md_op[0]) begin
                            r_lo <= bus.src_a;
                        end else begin
                            r_hi <= bus.src_a;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.cancel) begin
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_hi    <= r_pend[63:32];
                        r_lo    <= r_pend[31:0];
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.hilo_rdata = bus.mdm_sel ? r_lo : r_hi;
    assign bus.busy       = r_busy;
    assign bus.hi_q       = r_hi;
    assign bus.lo_q       = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expectations queued at issue,
// checked by a monitor when busy falls, plus direct HI/LO read checks.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          ncyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    mdu_hilo_if bus ();

    mdu_hilo #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string nm,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input int ncyc, input bit push);
        exp_t e;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.start = 1'b1;
        if (push) begin
            e.name = nm;
            e.hi = hi;
            e.lo = lo;
            e.ncyc = ncyc;
            sb.push_back(e);
        end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (bus.busy && k < 60) begin
            tick();
            k++;
        end
        if (bus.busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: busy still %b required 0", nm, bus.busy);
        end
    endtask

    // Monitor: one completion per falling edge of busy
    int busy_len = 0;
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            prev_busy = 1'b0;
            busy_len = 0;
        end else begin
            if (bus.busy) begin
                busy_len++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: hi %h lo %h none queued",
                             bus.hi_q, bus.lo_q);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, bus.hi_q, e.hi);
                    check({e.name, "_lo"}, bus.lo_q, e.lo);
                    check({e.name, "_cycles"}, 32'(busy_len), 32'(e.ncyc));
                end
                busy_len = 0;
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        bus.md_op = MD_MULT;
        bus.start = 1'b1;
        bus.md_we = 1'b0;
        bus.src_a = 32'd5;
        bus.src_b = 32'd5;
        bus.cancel = 1'b0;
        bus.mdm_sel = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        bus.start = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_hi", bus.hi_q, 32'd0);
        check("rst_lo", bus.lo_q, 32'd0);
        check("rst_rdata", bus.hilo_rdata, 32'd0);

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, "mult",
              32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b1);
        wait_idle("mult");
        bus.mdm_sel = 1'b0;
        #1 check("mult_rd_hi", bus.hilo_rdata, 32'hFFFF_FFFF);
        bus.mdm_sel = 1'b1;
        #1 check("mult_rd_lo", bus.hilo_rdata, 32'hFFFF_FFFA);

        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, "multu",
              32'h0000_0002, 32'hFFFF_FFFA, 5, 1'b1);
        wait_idle("multu");
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div",
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1);
        wait_idle("div");
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd0, "div0",
              32'hFFFF_FFF9, 32'hFFFF_FFFF, 10, 1'b1);
        wait_idle("div0");
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",
              32'h0000_0000, 32'h8000_0000, 10, 1'b1);
        wait_idle("div_ovf");

        issue(MD_DIVU, 32'd100, 32'd7, "cancel",
              32'h0000_0000, 32'h8000_0000, 4, 1'b1);
        repeat (3) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cancel_busy", {31'd0, bus.busy}, 32'd0);
        wait_idle("cancel");

        issue(MD_DIVU, 32'd100, 32'd7, "divu", 32'd2, 32'd14, 10, 1'b1);
        wait_idle("divu");

        issue(MD_MULT, 32'd7, 32'd6, "mt_busy", 32'd0, 32'd42, 5, 1'b1);
        bus.md_op = MD_MTLO;
        bus.src_a = 32'h1234;
        bus.md_we = 1'b1;
        tick();
        bus.md_we = 1'b0;
        bus.md_op = MD_MULT;
        wait_idle("mt_busy");

        bus.mdm_sel = 1'b1;
        bus.md_op = MD_MTLO;
        bus.src_a = 32'h1234;
        bus.md_we = 1'b1;
        #1 check("mtlo_nobypass", bus.hilo_rdata, 32'd42);
        tick();
        bus.md_we = 1'b0;
        check("mtlo_rd", bus.hilo_rdata, 32'h1234);
        bus.mdm_sel = 1'b0;
        bus.md_op = MD_MTHI;
        bus.src_a = 32'hABCD;
        bus.md_we = 1'b1;
        tick();
        bus.md_we = 1'b0;
        check("mthi_rd", bus.hilo_rdata, 32'hABCD);

        bus.md_op = 3'b110;
        bus.src_a = 32'hDEAD;
        bus.md_we = 1'b1;
        tick();
        bus.md_we = 1'b0;
        check("rsvd_hi", bus.hi_q, 32'hABCD);
        check("rsvd_lo", bus.lo_q, 32'h1234);

        bus.md_op = MD_MULT;
        bus.start = 1'b1;
        bus.cancel = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        check("startcancel_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        check("startcancel_busy2", {31'd0, bus.busy}, 32'd0);

        issue(MD_MULT, 32'd2, 32'd2, "cancel_last",
              32'hABCD, 32'h1234, 5, 1'b1);
        repeat (4) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        wait_idle("cancel_last");

        issue(MD_MULTU, 32'd2, 32'd3, "b2b_mul", 32'd0, 32'd6, 5, 1'b1);
        wait_idle("b2b_mul");
        issue(MD_DIVU, 32'd6, 32'd4, "b2b_div", 32'd2, 32'd1, 10, 1'b1);
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_idle("b2b_div");

        issue(MD_MULT, 32'd9, 32'd9, "rst_run", 32'd0, 32'd0, 5, 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("rstrun_busy", {31'd0, bus.busy}, 32'd0);
        check("rstrun_hi", bus.hi_q, 32'd0);
        check("rstrun_lo", bus.lo_q, 32'd0);

        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
